// File: rtl/seg_disp_monitor_pkg.sv
// Shared definitions for the two-digit seven-segment monitor: segment patterns,
// widths, FSM state type and the digit-pair to binary helper.
package seg_disp_monitor_pkg;

  localparam int SEG_W = 7;
  localparam int DIG_W = 4;
  localparam int CNT_W = 4;

  // Bit order g,f,e,d,c,b,a (MSB..LSB), segments active-high.
  localparam logic [SEG_W-1:0] SEG_0 = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRACK = 2'd2
  } state_e;

  // 10*tens + ones using shifts; result never exceeds 99.
  function automatic logic [6:0] pair_to_bin(input logic [DIG_W-1:0] tens,
                                             input logic [DIG_W-1:0] ones);
    logic [6:0] t;
    t = {3'b000, tens};
    return (t << 3) + (t << 1) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/seg_disp_monitor_seg7_dec.sv
// Combinational seven-segment to decimal digit decoder with a legality flag.
module seg7_dec
  import seg_disp_monitor_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [DIG_W-1:0] digit,
  output logic             legal
);

  always_comb begin
    digit = '0;
    legal = 1'b1;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_disp_monitor.sv
// Monitors an asynchronous two-digit seven-segment bus: synchronizes, debounces,
// decodes, and flags illegal patterns and breaks in the counting sequence.
module seg_disp_monitor
  import seg_disp_monitor_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [13:0]      seg_in,
  input  logic             chk_en,
  output logic [6:0]       dec_val,
  output logic             dec_valid,
  output logic             pat_err,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYC);

  logic [13:0]      sync1_q, sync1_d, sync2_q, sync2_d, samp_q, samp_d;
  logic [13:0]      acc_pat_q, acc_pat_d;
  logic             acc_vld_q, acc_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [6:0]       prev_q, prev_d, dec_val_q, dec_val_d;
  logic             dec_valid_q, dec_valid_d, pat_err_q, pat_err_d, seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [DIG_W-1:0] tens_dig, ones_dig;
  logic             tens_ok, ones_ok;

  logic       same, stable, legal, is_new, accept, in_seq;
  logic [6:0] value, exp_next;

  seg7_dec u_dec_tens (.seg(sync2_q[13:7]), .digit(tens_dig), .legal(tens_ok));
  seg7_dec u_dec_ones (.seg(sync2_q[6:0]),  .digit(ones_dig), .legal(ones_ok));

  always_comb begin
    sync1_d = seg_in;
    sync2_d = sync1_q;
    samp_d  = sync2_q;

    same = (sync2_q == samp_q);
    if (!same)                 cnt_d = CNT_W'(1);
    else if (cnt_q == STABLE_N) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CNT_W'(1);
    // Fire only on the cycle the count first lands on the threshold.
    stable = (cnt_d == STABLE_N) && (!same || (cnt_q != STABLE_N));

    legal    = tens_ok && ones_ok;
    value    = pair_to_bin(tens_dig, ones_dig);
    is_new   = !acc_vld_q || (sync2_q != acc_pat_q);
    accept   = stable && legal && is_new;
    exp_next = (prev_q == 7'd99) ? 7'd0 : prev_q + 7'd1;
    in_seq   = (value == exp_next) || (value == 7'd0);

    pat_err_d   = stable && !legal;
    seq_err_d   = accept && (state_q == ST_TRACK) && !in_seq;
    dec_valid_d = accept;
    dec_val_d   = accept ? value : dec_val_q;
    acc_pat_d   = accept ? sync2_q : acc_pat_q;
    acc_vld_d   = acc_vld_q || accept;

    err_cnt_d = err_cnt_q;
    if ((pat_err_d || seq_err_d) && (err_cnt_q != {ERR_W{1'b1}}))
      err_cnt_d = err_cnt_q + ERR_W'(1);

    state_d = state_q;
    prev_d  = prev_q;
    if (!chk_en) begin
      state_d = ST_IDLE;
      prev_d  = 7'd0;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_ARMED;
        ST_ARMED: if (accept) begin
          state_d = ST_TRACK;
          prev_d  = value;
        end
        ST_TRACK: if (accept) prev_d = value;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      samp_q      <= '0;
      cnt_q       <= '0;
      acc_pat_q   <= '0;
      acc_vld_q   <= 1'b0;
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      dec_val_q   <= '0;
      dec_valid_q <= 1'b0;
      pat_err_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      samp_q      <= samp_d;
      cnt_q       <= cnt_d;
      acc_pat_q   <= acc_pat_d;
      acc_vld_q   <= acc_vld_d;
      state_q     <= state_d;
      prev_q      <= prev_d;
      dec_val_q   <= dec_val_d;
      dec_valid_q <= dec_valid_d;
      pat_err_q   <= pat_err_d;
      seq_err_q   <= seq_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign dec_val   = dec_val_q;
  assign dec_valid = dec_valid_q;
  assign pat_err   = pat_err_q;
  assign seq_err   = seq_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_seg_disp_monitor.sv
// Directed bench for seg_disp_monitor: hand-computed expectations checked with
// immediate assertions after each held pattern.
module tb_seg_disp_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] seg_in;
  logic        chk_en;
  logic [6:0]  dec_val;
  logic        dec_valid, pat_err, seq_err;
  logic [7:0]  err_cnt;

  int checks   = 0;
  int failures = 0;
  int n_valid, n_pat, n_seq, first_edge, pat_total;

  seg_disp_monitor #(.STABLE_CYC(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .chk_en(chk_en),
    .dec_val(dec_val), .dec_valid(dec_valid), .pat_err(pat_err),
    .seq_err(seq_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      default: return 7'b1101111;
    endcase
  endfunction

  function automatic logic [13:0] pair(input int t, input int o);
    return {seg_of(t), seg_of(o)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply a pattern at a falling edge (also releasing reset) and watch n rising edges.
  task automatic hold(input logic [13:0] pat, input int n);
    @(negedge clk);
    seg_in = pat;
    rst    = 1'b1;
    n_valid = 0; n_pat = 0; n_seq = 0; first_edge = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if ((dec_valid || pat_err) && first_edge == 0) first_edge = i;
      if (dec_valid) n_valid++;
      if (pat_err)   n_pat++;
      if (seq_err)   n_seq++;
    end
  endtask

  task automatic check_hold(input string tag, input int ev, input int ep, input int es,
                            input int dv, input int ec, input int fe);
    chk({tag, ".valid"}, n_valid, ev);
    chk({tag, ".pat_err"}, n_pat, ep);
    chk({tag, ".seq_err"}, n_seq, es);
    chk({tag, ".dec_val"}, dec_val, dv);
    chk({tag, ".err_cnt"}, err_cnt, ec);
    if (fe != 0) chk({tag, ".edge"}, first_edge, fe);
    $display("step %s: valid=%0d pat=%0d seq=%0d dec_val=%0d err_cnt=%0d edge=%0d",
             tag, n_valid, n_pat, n_seq, dec_val, err_cnt, first_edge);
  endtask

  initial begin
    rst = 1'b0; chk_en = 1'b1; seg_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.dec_val", dec_val, 0);
    chk("rst.dec_valid", dec_valid, 0);
    chk("rst.pat_err", pat_err, 0);
    chk("rst.seq_err", seq_err, 0);
    chk("rst.err_cnt", err_cnt, 0);

    hold(pair(4, 2), 10); check_hold("v42", 1, 0, 0, 42, 0, 6);
    hold(pair(4, 3), 10); check_hold("v43", 1, 0, 0, 43, 0, 6);
    hold(pair(4, 4), 10); check_hold("v44", 1, 0, 0, 44, 0, 6);

    @(negedge clk); chk_en = 1'b0;
    @(negedge clk); chk_en = 1'b1;
    hold(pair(9, 8), 10); check_hold("v98", 1, 0, 0, 98, 0, 6);
    hold(pair(9, 9), 10); check_hold("v99", 1, 0, 0, 99, 0, 6);
    hold(pair(0, 0), 10); check_hold("v00", 1, 0, 0, 0, 0, 6);
    hold(pair(0, 5), 10); check_hold("v05", 1, 0, 1, 5, 1, 6);

    @(negedge clk); chk_en = 1'b0;
    hold(pair(4, 3), 10); check_hold("g43", 1, 0, 0, 43, 1, 6);
    hold(pair(4, 4), 2);  check_hold("g44", 0, 0, 0, 43, 1, 0);
    hold(pair(4, 3), 10); check_hold("g43b", 0, 0, 0, 43, 1, 0);

    hold({7'b0000000, seg_of(3)}, 10); check_hold("blank", 0, 1, 0, 43, 2, 6);

    pat_total = 0;
    for (int i = 0; i < 300; i++) begin
      hold((i % 2 == 0) ? 14'b0 : {7'b0000000, seg_of(3)}, 6);
      pat_total += n_pat;
    end
    chk("sat.pat_total", pat_total, 300);
    chk("sat.err_cnt", err_cnt, 255);
    chk("sat.dec_val", dec_val, 43);
    $display("step sat: pat_total=%0d err_cnt=%0d", pat_total, err_cnt);

    @(negedge clk); chk_en = 1'b1;
    hold(pair(2, 0), 10); check_hold("v20", 1, 0, 0, 20, 255, 6);
    hold(pair(2, 1), 10); check_hold("v21", 1, 0, 0, 21, 255, 6);

    @(negedge clk); seg_in = pair(2, 2);
    repeat (3) @(posedge clk);
    #2; rst = 1'b0; seg_in = pair(1, 7);
    #1;
    chk("arst.dec_val", dec_val, 0);
    chk("arst.dec_valid", dec_valid, 0);
    chk("arst.pat_err", pat_err, 0);
    chk("arst.seq_err", seq_err, 0);
    chk("arst.err_cnt", err_cnt, 0);
    $display("step arst: dec_val=%0d err_cnt=%0d", dec_val, err_cnt);

    hold(pair(1, 7), 10); check_hold("v17", 1, 0, 0, 17, 0, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_disp_monitor.md
SEG_DISP_MONITOR -- requirements
Module: seg_disp_monitor

Interface
REQ-001 Parameter: STABLE_CYC, default 4, number of consecutive equal synchronized samples required before a pattern is accepted (legal range 1..15).
REQ-002 Parameter: ERR_W, default 8, width of the saturating error counter.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset; asynchronous and active-low.
REQ-005 seg_in  input  14  two-digit display pattern; [13:7] tens digit, [6:0] ones digit; bit order g,f,e,d,c,b,a (MSB..LSB); segments active-high; asynchronous to clk.
REQ-006 chk_en  input  1  enables sequence checking; 0 forces IDLE.
REQ-007 dec_val  output  7  last accepted decoded value, 0..99.
REQ-008 dec_valid  output  1  one-cycle pulse when a new value is accepted.
REQ-009 pat_err  output  1  one-cycle pulse when a stable pattern is not a legal digit pair.
REQ-010 seq_err  output  1  one-cycle pulse when an accepted value breaks count sequence.
REQ-011 err_cnt  output  ERR_W  saturating count of pat_err plus seq_err events.

Function
REQ-012 seg_in shall pass through a 2-flop synchronizer before any other use.
REQ-013 A stability counter shall increment while the synchronized sample equals the previous sample, and reload to 1 on any difference; it shall saturate at STABLE_CYC.
REQ-014 A sample is "stable" in the cycle the counter first reaches STABLE_CYC; stability fires at most once per held pattern.
REQ-015 With seg_in held, dec_valid/pat_err shall pulse exactly STABLE_CYC+2 rising edges after the seg_in change.
REQ-016 Legal digit patterns: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; all others, including blank, are illegal.
REQ-017 Stable pattern with either digit illegal: pat_err pulses, err_cnt increments, dec_val unchanged, no dec_valid.
REQ-018 Stable legal pattern: dec_val = 10*tens + ones, registered; dec_valid pulses in the same cycle dec_val updates.
REQ-019 A stable pattern identical to the last accepted pattern shall not re-pulse dec_valid (only reachable after an intervening change).
REQ-020 FSM states IDLE, ARMED, TRACK; IDLE->ARMED when chk_en=1; ARMED->TRACK on first accepted value (no seq check); any state->IDLE when chk_en=0.
REQ-021 In TRACK, an accepted value v is in sequence iff v == (prev+1) mod 100 or v == 0; otherwise seq_err pulses with dec_valid, err_cnt increments, and v becomes the new prev.
REQ-022 Wrap-around: 99 followed by 0 is in sequence.
REQ-023 Decoding and dec_valid operate in all FSM states; seq_err only in TRACK.
REQ-024 err_cnt shall hold at 2^ERR_W-1; pat_err and seq_err cannot coincide (single event per cycle, +1 max).
REQ-025 chk_en deassertion mid-operation shall clear prev reference but not dec_val or err_cnt.

Reset
REQ-026 On rst low, immediately: synchronizer flops and stored pattern = 0, stability counter = 0, FSM = IDLE, dec_val = 0, dec_valid = pat_err = seq_err = 0, err_cnt = 0.
REQ-027 After rst release, the first stable pattern shall be treated as new regardless of value.

Structure
REQ-028 A shared package shall hold the ten segment pattern constants, the digit-pattern width (7), and the FSM state typedef.
REQ-029 One combinational sub-module seg7_dec (7-bit pattern in, 4-bit digit and legal flag out) shall be instantiated twice.

Verification
REQ-030 Reset, chk_en=1, seg_in=14'b1100110_1011011 (42) held -> dec_valid at edge STABLE_CYC+2 (6), dec_val=42, no errors.
REQ-031 Sequence 42,43,44 each held 10 cycles -> three dec_valid pulses, seq_err never, err_cnt=0.
REQ-032 Sequence 98,99,00 then 05 -> wrap accepted silently; 05 gives seq_err with dec_valid, dec_val=5, err_cnt=1.
REQ-033 Glitch: 43 then 44 for 2 cycles then back to 43, STABLE_CYC=4 -> no dec_valid, no error.
REQ-034 seg_in tens=0000000 (blank) ones legal, held -> pat_err pulse, dec_val unchanged, err_cnt+1; force 300 errors with ERR_W=8 -> err_cnt=255.
REQ-035 rst low mid-hold during TRACK -> all outputs 0 asynchronously; after release, next stable 17 gives dec_valid, no seq_err.
